// File: rtl/bus_pkg.sv
// Shared types for the two-core MSI snoop bus: bus operations, MSI states,
// FSM encodings and the snoop hit / next-state rules.
package bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NON  = 2'b11
  } bus_op_t;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_t;

  localparam logic [1:0] L2_HIT = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'b00,
    R_REQ  = 2'b01,
    R_RESP = 2'b10
  } req_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ACT  = 2'b01,
    S_UPD  = 2'b10
  } snp_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] state;
  } msi_upd_t;

  // A valid local copy supplies data to a peer read; an upgrade never needs it.
  function automatic logic snoop_hits(bus_op_t op, logic [1:0] st);
    return ((op == BUS_RD) || (op == BUS_RDX)) && ((st == MSI_M) || (st == MSI_S));
  endfunction

  function automatic msi_upd_t msi_next(bus_op_t op, logic [1:0] st);
    msi_upd_t u;
    u = '{valid: 1'b0, state: MSI_I};
    if (op == BUS_RDX)                        u = '{valid: 1'b1, state: MSI_I};
    else if ((op == BUS_RD) && (st == MSI_M))   u = '{valid: 1'b1, state: MSI_S};
    else if ((op == BUS_UPGR) && (st == MSI_S)) u = '{valid: 1'b1, state: MSI_I};
    return u;
  endfunction

endpackage

// File: rtl/l1_bus_agent_if.sv
// Bus-side bundle between an L1 agent (master) and the snoop bus controller (slave).
interface l1_bus_agent_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_core;
  logic              stall_core;
  logic [1:0]        bus_op_out;
  logic [ADDR_W-1:0] bus_addr_out;
  logic              grant;
  logic [DATA_W-1:0] bus_data_in;
  logic              peer_hit_in;
  logic [1:0]        l2_hit_in;
  logic [1:0]        snoop_op_in;
  logic [ADDR_W-1:0] snoop_addr_in;
  logic              snoop_hit_out;
  logic [DATA_W-1:0] snoop_data_out;

  modport master (
    output req_core, stall_core, bus_op_out, bus_addr_out, snoop_hit_out, snoop_data_out,
    input  grant, bus_data_in, peer_hit_in, l2_hit_in, snoop_op_in, snoop_addr_in
  );

  modport slave (
    input  req_core, stall_core, bus_op_out, bus_addr_out, snoop_hit_out, snoop_data_out,
    output grant, bus_data_in, peer_hit_in, l2_hit_in, snoop_op_in, snoop_addr_in
  );
endinterface

// File: rtl/bus_snoop_responder.sv
// Snooper side of the L1 agent: answers a forwarded peer operation and issues
// the MSI state write once that peer transaction ends. reset is active-low.
module bus_snoop_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        snoop_op_in,
  input  logic [ADDR_W-1:0] snoop_addr_in,
  input  logic [1:0]        lkp_state,
  input  logic [DATA_W-1:0] lkp_data,
  output logic              snoop_hit_out,
  output logic [DATA_W-1:0] snoop_data_out,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [1:0]        upd_state
);

  snp_state_t        snp_state_q, snp_state_d;
  bus_op_t           cap_op_q, cap_op_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [1:0]        cap_state_q, cap_state_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;

  logic     snoop_live;
  logic     same_txn;
  logic     capture;
  bus_op_t  live_op;
  msi_upd_t upd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snp_state_q <= S_IDLE;
      cap_op_q    <= BUS_NON;
      cap_addr_q  <= '0;
      cap_state_q <= MSI_I;
      cap_data_q  <= '0;
    end else begin
      snp_state_q <= snp_state_d;
      cap_op_q    <= cap_op_d;
      cap_addr_q  <= cap_addr_d;
      cap_state_q <= cap_state_d;
      cap_data_q  <= cap_data_d;
    end
  end

  always_comb begin
    snp_state_d    = snp_state_q;
    cap_op_d       = cap_op_q;
    cap_addr_d     = cap_addr_q;
    cap_state_d    = cap_state_q;
    cap_data_d     = cap_data_q;
    snoop_hit_out  = 1'b0;
    snoop_data_out = '0;
    upd_valid      = 1'b0;
    upd_addr       = '0;
    upd_state      = MSI_I;
    capture        = 1'b0;

    live_op    = bus_op_t'(snoop_op_in);
    snoop_live = (live_op != BUS_NON);
    same_txn   = snoop_live && (live_op == cap_op_q) && (snoop_addr_in == cap_addr_q);
    upd        = msi_next(cap_op_q, cap_state_q);

    unique case (snp_state_q)
      S_IDLE: capture = snoop_live;
      S_ACT: begin
        // Held snapshot keeps the answer stable while the peer stalls on the bus.
        if (same_txn) begin
          snoop_hit_out  = snoop_hits(cap_op_q, cap_state_q);
          snoop_data_out = snoop_hit_out ? cap_data_q : '0;
        end else begin
          snp_state_d = S_UPD;
        end
      end
      S_UPD: begin
        upd_valid = upd.valid;
        if (upd.valid) begin
          upd_addr  = cap_addr_q;
          upd_state = upd.state;
        end
        capture = snoop_live;
        if (!snoop_live) snp_state_d = S_IDLE;
      end
      default: snp_state_d = S_IDLE;
    endcase

    if (capture) begin
      cap_op_d       = live_op;
      cap_addr_d     = snoop_addr_in;
      cap_state_d    = lkp_state;
      cap_data_d     = lkp_data;
      snp_state_d    = S_ACT;
      snoop_hit_out  = snoop_hits(live_op, lkp_state);
      snoop_data_out = snoop_hit_out ? lkp_data : '0;
    end

    // The capture-cycle answer is combinational, so it must be masked in reset too.
    if (!reset) begin
      snoop_hit_out  = 1'b0;
      snoop_data_out = '0;
    end
  end

endmodule

// File: rtl/l1_bus_agent.sv
// Per-core L1 agent on the two-core MSI snoop bus: requester FSM plus the snoop
// responder. reset is asynchronous and active-low.
module l1_bus_agent
  import bus_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RETRY_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req_valid,
  input  logic [1:0]        cpu_req_op,
  input  logic [ADDR_W-1:0] cpu_req_addr,
  output logic              cpu_req_ready,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_resp_data,
  output logic [1:0]        cpu_resp_state,
  output logic              cpu_resp_err,
  l1_bus_agent_if.master    bus,
  output logic [ADDR_W-1:0] lkp_addr,
  input  logic [1:0]        lkp_state,
  input  logic [DATA_W-1:0] lkp_data,
  output logic              upd_valid,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [1:0]        upd_state
);

  localparam int RETRY_W = $clog2(RETRY_MAX + 1);

  req_state_t         req_state_q, req_state_d;
  bus_op_t            op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic [1:0]         resp_state_q, resp_state_d;
  logic               resp_err_q, resp_err_d;

  logic data_src;
  logic upgr_killed;

  assign lkp_addr = bus.snoop_addr_in;

  bus_snoop_responder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_snoop (
    .clk            (clk),
    .reset          (reset),
    .snoop_op_in    (bus.snoop_op_in),
    .snoop_addr_in  (bus.snoop_addr_in),
    .lkp_state      (lkp_state),
    .lkp_data       (lkp_data),
    .snoop_hit_out  (bus.snoop_hit_out),
    .snoop_data_out (bus.snoop_data_out),
    .upd_valid      (upd_valid),
    .upd_addr       (upd_addr),
    .upd_state      (upd_state)
  );

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_state_q  <= R_IDLE;
      op_q         <= BUS_NON;
      addr_q       <= '0;
      retry_q      <= '0;
      resp_data_q  <= '0;
      resp_state_q <= MSI_I;
      resp_err_q   <= 1'b0;
    end else begin
      req_state_q  <= req_state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      retry_q      <= retry_d;
      resp_data_q  <= resp_data_d;
      resp_state_q <= resp_state_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // A peer upgrade/RdX ending on our line leaves no S copy to upgrade.
  assign upgr_killed = upd_valid && (upd_state == MSI_I) && (upd_addr == addr_q) &&
                       (op_q == BUS_UPGR);
  assign data_src    = bus.peer_hit_in || (bus.l2_hit_in == L2_HIT);

  // NOTE: every output and next-state value gets a default first, so no path infers a latch.
  always_comb begin
    req_state_d    = req_state_q;
    op_d           = op_q;
    addr_d         = addr_q;
    retry_d        = retry_q;
    resp_data_d    = resp_data_q;
    resp_state_d   = resp_state_q;
    resp_err_d     = resp_err_q;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_data  = '0;
    cpu_resp_state = MSI_I;
    cpu_resp_err   = 1'b0;
    bus.req_core     = 1'b0;
    bus.stall_core   = 1'b0;
    bus.bus_op_out   = BUS_NON;
    bus.bus_addr_out = '0;

    unique case (req_state_q)
      R_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid && (cpu_req_op != BUS_NON)) begin
          op_d        = bus_op_t'(cpu_req_op);
          addr_d      = cpu_req_addr;
          retry_d     = '0;
          req_state_d = R_REQ;
        end
      end
      R_REQ: begin
        bus.req_core     = 1'b1;
        bus.stall_core   = 1'b1;
        bus.bus_op_out   = op_q;
        bus.bus_addr_out = addr_q;
        if (bus.grant && (op_q == BUS_UPGR)) begin
          resp_data_d  = '0;
          resp_state_d = MSI_M;
          resp_err_d   = 1'b0;
          req_state_d  = R_RESP;
        end else if (bus.grant && data_src) begin
          resp_data_d  = bus.bus_data_in;
          resp_state_d = (op_q == BUS_RD) ? MSI_S : MSI_M;
          resp_err_d   = 1'b0;
          req_state_d  = R_RESP;
        end else begin
          if (bus.grant) begin
            retry_d = retry_q + 1'b1;
            if (retry_q == RETRY_W'(RETRY_MAX - 1)) begin
              resp_data_d  = '0;
              resp_state_d = MSI_I;
              resp_err_d   = 1'b1;
              req_state_d  = R_RESP;
            end
          end
          if ((req_state_d == R_REQ) && upgr_killed) op_d = BUS_RDX;
        end
      end
      R_RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_data  = resp_data_q;
        cpu_resp_state = resp_state_q;
        cpu_resp_err   = resp_err_q;
        req_state_d    = R_IDLE;
      end
      default: req_state_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_bus_agent.sv
// Directed bench for l1_bus_agent: transaction-level model checked every cycle
// plus hand-computed literal expectations for each scenario.
module tb_l1_bus_agent;
  import bus_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RMAX = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          cpu_req_valid;
  logic [1:0]    cpu_req_op;
  logic [AW-1:0] cpu_req_addr;
  logic          cpu_req_ready, cpu_resp_valid, cpu_resp_err;
  logic [DW-1:0] cpu_resp_data;
  logic [1:0]    cpu_resp_state;
  logic [AW-1:0] lkp_addr, upd_addr;
  logic [1:0]    lkp_state, upd_state;
  logic [DW-1:0] lkp_data;
  logic          upd_valid;

  // One-line L1 array seen through the lookup port.
  logic [AW-1:0] l1_addr;
  logic [1:0]    l1_st;
  logic [DW-1:0] l1_dat;
  assign lkp_state = (lkp_addr == l1_addr) ? l1_st : 2'b00;
  assign lkp_data  = (lkp_addr == l1_addr) ? l1_dat : '0;

  l1_bus_agent_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  l1_bus_agent #(.ADDR_W(AW), .DATA_W(DW), .RETRY_MAX(RMAX)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_op     (cpu_req_op),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_data  (cpu_resp_data),
    .cpu_resp_state (cpu_resp_state),
    .cpu_resp_err   (cpu_resp_err),
    .bus            (bus),
    .lkp_addr       (lkp_addr),
    .lkp_state      (lkp_state),
    .lkp_data       (lkp_data),
    .upd_valid      (upd_valid),
    .upd_addr       (upd_addr),
    .upd_state      (upd_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model, compared at every negedge ----------------
  bit            m_busy, m_resp, m_rerr;
  logic [1:0]    m_op, m_rstate;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_rdata;
  int            m_fails;
  bit            s_open, s_uv;
  logic [1:0]    s_op, s_st, s_ust;
  logic [AW-1:0] s_addr, s_uaddr;
  logic [DW-1:0] s_dat;

  function automatic bit peer_wants_data(logic [1:0] op, logic [1:0] st);
    return (op inside {2'b00, 2'b10}) && (st inside {2'b01, 2'b10});
  endfunction

  initial begin
    bit            e_hit, same, src;
    logic [1:0]    e_st;
    logic [DW-1:0] e_dat;
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_busy = 0; m_resp = 0; m_fails = 0; s_open = 0; s_uv = 0;
      end
      check("m_ready", cpu_req_ready, !m_busy && !m_resp);
      check("m_req_core", bus.req_core, m_busy);
      check("m_stall", bus.stall_core, m_busy);
      check("m_bus_op", bus.bus_op_out, m_busy ? m_op : 2'b11);
      check("m_bus_addr", bus.bus_addr_out, m_busy ? m_addr : '0);
      check("m_resp_valid", cpu_resp_valid, m_resp);
      if (m_resp) begin
        check("m_resp_err", cpu_resp_err, m_rerr);
        if (!m_rerr) begin
          check("m_resp_data", cpu_resp_data, m_rdata);
          check("m_resp_state", cpu_resp_state, m_rstate);
        end
      end
      same  = (bus.snoop_op_in != 2'b11) && (bus.snoop_op_in == s_op) && (bus.snoop_addr_in == s_addr);
      e_hit = 0; e_dat = '0;
      if (reset && bus.snoop_op_in != 2'b11) begin
        if (!s_open) begin
          e_hit = peer_wants_data(bus.snoop_op_in, lkp_state);
          e_dat = e_hit ? lkp_data : '0;
        end else if (same) begin
          e_hit = peer_wants_data(s_op, s_st);
          e_dat = e_hit ? s_dat : '0;
        end
      end
      check("m_snoop_hit", bus.snoop_hit_out, e_hit);
      check("m_snoop_data", bus.snoop_data_out, e_dat);
      check("m_lkp_addr", lkp_addr, bus.snoop_addr_in);
      check("m_upd_valid", upd_valid, s_uv);
      if (s_uv) begin
        check("m_upd_addr", upd_addr, s_uaddr);
        check("m_upd_state", upd_state, s_ust);
      end
      if (reset) begin
        // requester: what the next cycle must show
        src = bus.peer_hit_in || (bus.l2_hit_in == 2'b10);
        if (m_resp) m_resp = 0;
        else if (!m_busy) begin
          if (cpu_req_valid && cpu_req_op != 2'b11) begin
            m_busy = 1; m_op = cpu_req_op; m_addr = cpu_req_addr; m_fails = 0;
          end
        end else if (bus.grant && (m_op == 2'b01 || src)) begin
          m_busy = 0; m_resp = 1; m_rerr = 0;
          m_rdata  = (m_op == 2'b01) ? '0 : bus.bus_data_in;
          m_rstate = (m_op == 2'b00) ? 2'b01 : 2'b10;
        end else begin
          if (bus.grant) m_fails++;
          if (m_fails == RMAX) begin
            m_busy = 0; m_resp = 1; m_rerr = 1;
          end else if (s_uv && s_ust == 2'b00 && s_uaddr == m_addr && m_op == 2'b01) begin
            m_op = 2'b10;
          end
        end
        // snooper: a peer transaction ends when its op/addr disappears
        s_uv = 0;
        if (s_open && !same) begin
          s_open = 0;
          e_st = 2'bxx;
          if (s_op == 2'b10) e_st = 2'b00;
          else if (s_op == 2'b00 && s_st == 2'b10) e_st = 2'b01;
          else if (s_op == 2'b01 && s_st == 2'b01) e_st = 2'b00;
          s_uv = (e_st !== 2'bxx); s_ust = e_st; s_uaddr = s_addr;
        end else if (!s_open && bus.snoop_op_in != 2'b11) begin
          s_open = 1; s_op = bus.snoop_op_in; s_addr = bus.snoop_addr_in;
          s_st = lkp_state; s_dat = lkp_data;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    logic       w;
    logic [1:0] s;
    w = upd_valid && (upd_addr == l1_addr);
    s = upd_state;
    @(posedge clk);
    #1;
    if (w) l1_st = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    cpu_req_valid = 0; cpu_req_op = 2'b00; cpu_req_addr = '0;
    bus.grant = 0; bus.bus_data_in = '0; bus.peer_hit_in = 0; bus.l2_hit_in = 2'b00;
    bus.snoop_op_in = 2'b11; bus.snoop_addr_in = '0;
    l1_addr = 32'hFFFF_FFF0; l1_st = 2'b00; l1_dat = '0;

    repeat (2) @(posedge clk);
    #3;
    check("rst_ready", cpu_req_ready, 1);
    check("rst_bus_op", bus.bus_op_out, 2'b11);
    check("rst_req_core", bus.req_core, 0);
    check("rst_resp_valid", cpu_resp_valid, 0);
    check("rst_upd_valid", upd_valid, 0);
    reset = 1;

    // 1: BusRd, granted in first REQ cycle, peer supplies data
    tick(); cpu_req_valid = 1; cpu_req_op = 2'b00; cpu_req_addr = 32'h100; #2;
    check("t1_ready", cpu_req_ready, 1);
    tick(); cpu_req_valid = 0; bus.grant = 1; bus.peer_hit_in = 1; bus.bus_data_in = 32'hCAFE; #2;
    check("t1_req_core", bus.req_core, 1);
    check("t1_bus_op", bus.bus_op_out, 2'b00);
    check("t1_bus_addr", bus.bus_addr_out, 32'h100);
    tick(); bus.grant = 0; bus.peer_hit_in = 0; bus.bus_data_in = '0; #2;
    check("t1_resp_valid", cpu_resp_valid, 1);
    check("t1_resp_data", cpu_resp_data, 32'hCAFE);
    check("t1_resp_state", cpu_resp_state, 2'b01);
    check("t1_resp_err", cpu_resp_err, 0);
    tick(); #2;
    check("t1_resp_once", cpu_resp_valid, 0);

    // 2: BusRdX, grant after 3 idle cycles, L2 supplies data
    tick(); cpu_req_valid = 1; cpu_req_op = 2'b10; cpu_req_addr = 32'h200; cnt = 0;
    tick(); cpu_req_valid = 0; #2; cnt += int'(bus.stall_core);
    repeat (2) begin tick(); #2; cnt += int'(bus.stall_core); end
    tick(); bus.grant = 1; bus.l2_hit_in = 2'b10; bus.bus_data_in = 32'h1234; #2;
    cnt += int'(bus.stall_core);
    tick(); bus.grant = 0; bus.l2_hit_in = 2'b00; bus.bus_data_in = '0; #2;
    check("t2_stall_cycles", cnt, 4);
    check("t2_resp_data", cpu_resp_data, 32'h1234);
    check("t2_resp_state", cpu_resp_state, 2'b10);

    // 3: peer BusRd hits a local M line for 3 cycles, then ends
    tick(); l1_addr = 32'h300; l1_st = 2'b10; l1_dat = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick(); bus.snoop_op_in = 2'b00; bus.snoop_addr_in = 32'h300; #2;
      check("t3_hit", bus.snoop_hit_out, 1);
      check("t3_data", bus.snoop_data_out, 32'hBEEF);
    end
    tick(); bus.snoop_op_in = 2'b11; bus.snoop_addr_in = '0; #2;
    check("t3_hit_end", bus.snoop_hit_out, 0);
    tick(); #2;
    check("t3_upd_valid", upd_valid, 1);
    check("t3_upd_state", upd_state, 2'b01);
    check("t3_upd_addr", upd_addr, 32'h300);
    tick(); #2;
    check("t3_upd_once", upd_valid, 0);

    // 4: pending BusUpgr loses its S copy to a peer upgrade -> promoted to BusRdX
    tick(); l1_addr = 32'h400; l1_st = 2'b01; l1_dat = 32'h4444;
    cpu_req_valid = 1; cpu_req_op = 2'b01; cpu_req_addr = 32'h400;
    tick(); cpu_req_valid = 0; bus.snoop_op_in = 2'b01; bus.snoop_addr_in = 32'h400; #2;
    check("t4_bus_op_upgr", bus.bus_op_out, 2'b01);
    check("t4_snoop_nohit", bus.snoop_hit_out, 0);
    tick(); bus.snoop_op_in = 2'b11; bus.snoop_addr_in = '0;
    tick(); #2;
    check("t4_upd_valid", upd_valid, 1);
    check("t4_upd_state", upd_state, 2'b00);
    tick(); #2;
    check("t4_bus_op_rdx", bus.bus_op_out, 2'b10);
    tick(); bus.grant = 1; bus.l2_hit_in = 2'b10; bus.bus_data_in = 32'h5555;
    tick(); bus.grant = 0; bus.l2_hit_in = 2'b00; bus.bus_data_in = '0; #2;
    check("t4_resp_data", cpu_resp_data, 32'h5555);
    check("t4_resp_state", cpu_resp_state, 2'b10);

    // 5: granted with no data source for RETRY_MAX cycles -> error response
    tick(); cpu_req_valid = 1; cpu_req_op = 2'b00; cpu_req_addr = 32'h500;
    tick(); cpu_req_valid = 0; bus.grant = 1; bus.l2_hit_in = 2'b01; bus.bus_data_in = 32'hDEAD;
    repeat (RMAX - 1) tick();
    #2;
    check("t5_still_req", bus.req_core, 1);
    tick(); bus.grant = 0; bus.l2_hit_in = 2'b00; bus.bus_data_in = '0; #2;
    check("t5_resp_valid", cpu_resp_valid, 1);
    check("t5_resp_err", cpu_resp_err, 1);
    tick(); #2;
    check("t5_bus_op_idle", bus.bus_op_out, 2'b11);
    check("t5_ready", cpu_req_ready, 1);

    // 6a: reset in REQ aborts without a response
    tick(); cpu_req_valid = 1; cpu_req_op = 2'b00; cpu_req_addr = 32'h600;
    tick(); cpu_req_valid = 0; #2;
    check("t6_req_core", bus.req_core, 1);
    #1 reset = 0; #1;
    check("t6_rst_req_core", bus.req_core, 0);
    check("t6_rst_stall", bus.stall_core, 0);
    check("t6_rst_bus_op", bus.bus_op_out, 2'b11);
    tick(); tick(); reset = 1;
    bus.grant = 1; bus.peer_hit_in = 1; bus.bus_data_in = 32'hFFFF; cnt = 0;
    repeat (4) begin tick(); #2; cnt += int'(cpu_resp_valid); end
    check("t6_no_resp", cnt, 0);
    bus.grant = 0; bus.peer_hit_in = 0; bus.bus_data_in = '0;

    // 6b: reset in SACT aborts without an update
    tick(); l1_addr = 32'h700; l1_st = 2'b10; l1_dat = 32'h7777;
    bus.snoop_op_in = 2'b10; bus.snoop_addr_in = 32'h700; #2;
    check("t6_snoop_hit", bus.snoop_hit_out, 1);
    check("t6_snoop_data", bus.snoop_data_out, 32'h7777);
    tick(); #2;
    check("t6_sact_hit", bus.snoop_hit_out, 1);
    #1 reset = 0; #1;
    check("t6_rst_hit", bus.snoop_hit_out, 0);
    check("t6_rst_data", bus.snoop_data_out, 0);
    tick(); bus.snoop_op_in = 2'b11; bus.snoop_addr_in = '0;
    tick(); reset = 1; cnt = 0;
    repeat (4) begin tick(); #2; cnt += int'(upd_valid); end
    check("t6_no_upd", cnt, 0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
